ula_op_sequencer: RTL and testbench
===================================

Name: ula_op_sequencer

Overview:
- Initiator side of the ULA operations block's control interface.
- Accepts one opcode per valid/ready handshake and pops operands from the data stack into the ULA operand registers.
- Fires SEL_ULA, the overflow register strobe and the comparison-stack strobe in the right cycles, then pushes the arithmetic/logic result back onto the data stack.
- Owns the data-stack pointer and drives TOS for the comparison stack.

Parameters:
- DATA_WIDTH, 8, operand/result width.
- ADDR_WIDTH, 12, data-stack address width; stack capacity is 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- OP_VALID_IN  input  1  opcode request valid.
- OP_CODE_IN  input  4  ULA select code; 4'b1111 = push literal.
- OP_DATA_IN  input  DATA_WIDTH  literal for push.
- OP_READY_OUT  output  1  sequencer can accept an opcode.
- DONE_OUT  output  1  one-cycle pulse when an accepted opcode completes, including error completion.
- ERR_UNDERFLOW_OUT  output  1  one-cycle pulse: too few operands.
- ERR_FULL_OUT  output  1  one-cycle pulse: push onto a full stack.
- STACK_ADDR_OUT  output  ADDR_WIDTH  data-stack address.
- STACK_WE_OUT  output  1  data-stack write enable.
- STACK_WDATA_OUT  output  DATA_WIDTH  data-stack write data.
- STACK_RDATA_IN  input  DATA_WIDTH  data-stack read data; synchronous read, valid 1 cycle after the address.
- ULA_OPERAND_OUT  output  DATA_WIDTH  to the ULA operand input (shared by both operand registers).
- CTRL_REG_OP1  output  1  load operand register 1 (ULA_IN_1, top of stack).
- CTRL_REG_OP2  output  1  load operand register 2 (ULA_IN_2, second from top).
- CTRL_REG_OVERFLOW  output  1  capture the ULA overflow flag.
- CTRL_STACK_COMP  output  1  write the comparison bit.
- SEL_ULA  output  4  ULA operation select.
- ULA_RESULT_IN  input  DATA_WIDTH  ULA_OUT.
- TOS_OUT  output  ADDR_WIDTH  comparison-stack address.
- COUNT_OUT  output  ADDR_WIDTH+1  number of data-stack entries.

Behaviour:
- Opcode classes:
  - Binary ALU: 0000–0111.
  - Unary NOT: 1000.
  - Compare: 1001–1110.
  - Push: 1111.
- Stack pointer:
  - COUNT is ADDR_WIDTH+1 bits; the top element is at COUNT-1 and the next free slot at COUNT.
  - Full when COUNT == 2**ADDR_WIDTH.
  - TOS_OUT = COUNT[ADDR_WIDTH-1:0].
- States: IDLE, RD1, LD1, RD2, LD2, EXEC, PUSH, ERR.
- IDLE:
  - OP_READY_OUT=1; it is 0 in every other state.
  - On OP_VALID_IN & OP_READY_OUT, latch OP_CODE_IN and OP_DATA_IN.
  - Needed operands: 2 for binary/compare, 1 for NOT, 0 for push.
  - If COUNT < needed → ERR with underflow; push with full stack → ERR with full; push otherwise → PUSH; else → RD1.
- RD1: STACK_ADDR_OUT=COUNT-1 → LD1.
- LD1:
  - ULA_OPERAND_OUT=STACK_RDATA_IN, CTRL_REG_OP1=1, COUNT-=1.
  - → RD2 (binary/compare) or EXEC (NOT).
- RD2: STACK_ADDR_OUT=COUNT-1 → LD2.
- LD2: ULA_OPERAND_OUT=STACK_RDATA_IN, CTRL_REG_OP2=1, COUNT-=1 → EXEC.
- EXEC:
  - SEL_ULA=latched code; operand registers are already valid, so ULA_RESULT_IN is valid this cycle.
  - Codes 0000–1000: STACK_WE_OUT=1, STACK_ADDR_OUT=COUNT, STACK_WDATA_OUT=ULA_RESULT_IN, COUNT+=1.
  - Codes 0000–0100 additionally: CTRL_REG_OVERFLOW=1.
  - Compare codes: CTRL_STACK_COMP=1 at TOS_OUT (the post-pop COUNT); data stack not written.
  - DONE_OUT=1 → IDLE.
- PUSH: STACK_WE_OUT=1, addr=COUNT, data=latched literal, COUNT+=1, DONE_OUT=1 → IDLE.
- ERR:
  - The matching ERR_* and DONE_OUT pulse for 1 cycle.
  - COUNT unchanged; no CTRL_* or write strobe → IDLE.
- Latency from acceptance edge to DONE_OUT:
  - binary/compare: 5 cycles;
  - NOT: 3 cycles;
  - push and errors: 1 cycle.
- Default output levels:
  - SEL_ULA=4'b1111 outside EXEC (ULA_OUT and compare output 0, no overflow).
  - All strobes are 0 outside their state.
  - ULA_OPERAND_OUT=0 outside LD1/LD2.
- No new request is accepted until IDLE; back-to-back ops are separated by at least one IDLE cycle.
- Reset (rst_n=0 at a clock edge, including mid-operation):
  - state=IDLE, COUNT=0, latched code/literal=0.
  - All outputs 0 except SEL_ULA=4'b1111 and OP_READY_OUT=1 the cycle after reset is released.
  - A partially completed op is abandoned; no write is issued.

Test Plan:
- Reset, push 5, push 3, op 0000 → EXEC writes 8 at addr 0; COUNT 2→0→1; CTRL_REG_OP1 pulse with operand 3, CTRL_REG_OP2 pulse with operand 5; DONE 5 cycles after acceptance.
- Push 200, push 100, op 0000 → stored 44; CTRL_REG_OVERFLOW pulse in EXEC; push 7, push 2, op 0001 → stored 5.
- Push 4, push 9, op 1100 → CTRL_STACK_COMP pulse with TOS_OUT=0; ULA compare output 1; COUNT=0; STACK_WE_OUT never high in EXEC.
- Push 0x0F, op 1000 → stored 0xF0, DONE 3 cycles after acceptance; CTRL_REG_OP2 never pulses.
- Empty stack, op 0000 → ERR_UNDERFLOW_OUT and DONE_OUT pulse the cycle after acceptance, COUNT stays 0, no strobes; ADDR_WIDTH=2: 4 pushes OK, 5th → ERR_FULL_OUT, COUNT stays 4.
- Push 1, push 2, op 0000, drop rst_n in the LD2 cycle → no write, COUNT=0, OP_READY_OUT=1 after release; a subsequent push 6 is stored at addr 0.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// Control sequencer for the ULA operations block: pops operands from the data stack,
// strobes the ULA operand/overflow/compare registers and pushes the result back.
module ula_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  OP_VALID_IN,
    input  logic [3:0]            OP_CODE_IN,
    input  logic [DATA_WIDTH-1:0] OP_DATA_IN,
    output logic                  OP_READY_OUT,
    output logic                  DONE_OUT,
    output logic                  ERR_UNDERFLOW_OUT,
    output logic                  ERR_FULL_OUT,
    output logic [ADDR_WIDTH-1:0] STACK_ADDR_OUT,
    output logic                  STACK_WE_OUT,
    output logic [DATA_WIDTH-1:0] STACK_WDATA_OUT,
    input  logic [DATA_WIDTH-1:0] STACK_RDATA_IN,
    output logic [DATA_WIDTH-1:0] ULA_OPERAND_OUT,
    output logic                  CTRL_REG_OP1,
    output logic                  CTRL_REG_OP2,
    output logic                  CTRL_REG_OVERFLOW,
    output logic                  CTRL_STACK_COMP,
    output logic [3:0]            SEL_ULA,
    input  logic [DATA_WIDTH-1:0] ULA_RESULT_IN,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic [ADDR_WIDTH:0]   COUNT_OUT,
    output logic [2:0]            state_dbg
);

    // Handshake: an opcode transfers on any rising edge where OP_VALID_IN and
    // OP_READY_OUT are both high; OP_READY_OUT is high only in IDLE, so at most one
    // opcode is in flight and the requester may change its inputs freely otherwise.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        LD1  = 3'd2,
        RD2  = 3'd3,
        LD2  = 3'd4,
        EXEC = 3'd5,
        PUSH = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam logic [3:0]          CODE_NOT  = 4'b1000;
    localparam logic [3:0]          CODE_PUSH = 4'b1111;
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [3:0]            code_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_full_q, err_full_d;
    logic                  accept;
    logic [1:0]            needed;
    logic [ADDR_WIDTH:0]   count_m1;
    logic [ADDR_WIDTH:0]   needed_ext;

    assign count_m1   = count_q - CNT_ONE;
    assign needed_ext = {{(ADDR_WIDTH - 1){1'b0}}, needed};
    assign accept     = OP_VALID_IN && (state_q == IDLE);

    always_comb begin
        if (OP_CODE_IN == CODE_PUSH) begin
            needed = 2'd0;
        end else if (OP_CODE_IN == CODE_NOT) begin
            needed = 2'd1;
        end else begin
            needed = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            code_q     <= '0;
            data_q     <= '0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_full_q <= err_full_d;
            if (accept) begin
                code_q <= OP_CODE_IN;
                data_q <= OP_DATA_IN;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        err_full_d        = err_full_q;
        OP_READY_OUT      = 1'b0;
        DONE_OUT          = 1'b0;
        ERR_UNDERFLOW_OUT = 1'b0;
        ERR_FULL_OUT      = 1'b0;
        STACK_ADDR_OUT    = '0;
        STACK_WE_OUT      = 1'b0;
        STACK_WDATA_OUT   = '0;
        ULA_OPERAND_OUT   = '0;
        CTRL_REG_OP1      = 1'b0;
        CTRL_REG_OP2      = 1'b0;
        CTRL_REG_OVERFLOW = 1'b0;
        CTRL_STACK_COMP   = 1'b0;
        SEL_ULA           = 4'b1111;

        unique case (state_q)
            IDLE: begin
                OP_READY_OUT = 1'b1;
                if (OP_VALID_IN) begin
                    if (count_q < needed_ext) begin
                        state_d    = ERR;
                        err_full_d = 1'b0;
                    end else if (OP_CODE_IN == CODE_PUSH && count_q == CNT_FULL) begin
                        state_d    = ERR;
                        err_full_d = 1'b1;
                    end else if (OP_CODE_IN == CODE_PUSH) begin
                        state_d = PUSH;
                    end else begin
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                STACK_ADDR_OUT = count_m1[ADDR_WIDTH-1:0];
                state_d        = LD1;
            end
            LD1: begin
                ULA_OPERAND_OUT = STACK_RDATA_IN;
                CTRL_REG_OP1    = 1'b1;
                count_d         = count_m1;
                state_d         = (code_q == CODE_NOT) ? EXEC : RD2;
            end
            RD2: begin
                STACK_ADDR_OUT = count_m1[ADDR_WIDTH-1:0];
                state_d        = LD2;
            end
            LD2: begin
                ULA_OPERAND_OUT = STACK_RDATA_IN;
                CTRL_REG_OP2    = 1'b1;
                count_d         = count_m1;
                state_d         = EXEC;
            end
            EXEC: begin
                SEL_ULA  = code_q;
                DONE_OUT = 1'b1;
                // Arithmetic/logic results go back on the stack; compares only set a bit
                // at the post-pop top-of-stack position.
                if (code_q <= CODE_NOT) begin
                    STACK_WE_OUT      = 1'b1;
                    STACK_ADDR_OUT    = count_q[ADDR_WIDTH-1:0];
                    STACK_WDATA_OUT   = ULA_RESULT_IN;
                    count_d           = count_q + CNT_ONE;
                    CTRL_REG_OVERFLOW = (code_q <= 4'b0100);
                end else begin
                    CTRL_STACK_COMP = 1'b1;
                end
                state_d = IDLE;
            end
            PUSH: begin
                STACK_WE_OUT    = 1'b1;
                STACK_ADDR_OUT  = count_q[ADDR_WIDTH-1:0];
                STACK_WDATA_OUT = data_q;
                count_d         = count_q + CNT_ONE;
                DONE_OUT        = 1'b1;
                state_d         = IDLE;
            end
            ERR: begin
                DONE_OUT          = 1'b1;
                ERR_FULL_OUT      = err_full_q;
                ERR_UNDERFLOW_OUT = !err_full_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign TOS_OUT   = count_q[ADDR_WIDTH-1:0];
    assign COUNT_OUT = count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Bench for ula_op_sequencer: stack memory and ULA fixtures, a stack-machine model
// feeding an expected-write queue, and per-opcode strobe/latency checks.
module tb_ula_op_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic [3:0]    op_code;
    logic [DW-1:0] op_data;
    logic          op_ready;
    logic          done;
    logic          err_uf;
    logic          err_full;
    logic [AW-1:0] stack_addr;
    logic          stack_we;
    logic [DW-1:0] stack_wdata;
    logic [DW-1:0] stack_rdata;
    logic [DW-1:0] ula_operand;
    logic          ctrl_op1;
    logic          ctrl_op2;
    logic          ctrl_ovf;
    logic          ctrl_comp;
    logic [3:0]    sel_ula;
    logic [DW-1:0] ula_result;
    logic [AW-1:0] tos;
    logic [AW:0]   count;
    logic [2:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    int we_total = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    m_stack[DEPTH];
    int               m_count;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    ula_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .OP_VALID_IN       (op_valid),
        .OP_CODE_IN        (op_code),
        .OP_DATA_IN        (op_data),
        .OP_READY_OUT      (op_ready),
        .DONE_OUT          (done),
        .ERR_UNDERFLOW_OUT (err_uf),
        .ERR_FULL_OUT      (err_full),
        .STACK_ADDR_OUT    (stack_addr),
        .STACK_WE_OUT      (stack_we),
        .STACK_WDATA_OUT   (stack_wdata),
        .STACK_RDATA_IN    (stack_rdata),
        .ULA_OPERAND_OUT   (ula_operand),
        .CTRL_REG_OP1      (ctrl_op1),
        .CTRL_REG_OP2      (ctrl_op2),
        .CTRL_REG_OVERFLOW (ctrl_ovf),
        .CTRL_STACK_COMP   (ctrl_comp),
        .SEL_ULA           (sel_ula),
        .ULA_RESULT_IN     (ula_result),
        .TOS_OUT           (tos),
        .COUNT_OUT         (count),
        .state_dbg         (state_dbg)
    );

    // ULA behaviour: a = operand reg 1 (top of stack), b = operand reg 2
    function automatic logic ula_cmp(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (sel)
            4'd9:    return b == a;
            4'd10:   return b != a;
            4'd11:   return b > a;
            4'd12:   return b < a;
            4'd13:   return b >= a;
            4'd14:   return b <= a;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] ula_fn(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (sel)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            4'd3:    return b | a;
            4'd4:    return b ^ a;
            4'd5:    return b & ~a;
            4'd6:    return b | ~a;
            4'd7:    return ~(b & a);
            4'd8:    return ~a;
            4'd15:   return '0;
            default: return {{(DW-1){1'b0}}, ula_cmp(sel, a, b)};
        endcase
    endfunction

    logic [DW-1:0] mem[DEPTH];
    logic [DW-1:0] ula_r1, ula_r2;
    logic          cmp_bit;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ula_r1 = '0;
        ula_r2 = '0;
    end

    always @(posedge clk) begin
        if (stack_we) mem[stack_addr] <= stack_wdata;
        stack_rdata <= mem[stack_addr];
        if (ctrl_op1) ula_r1 <= ula_operand;
        if (ctrl_op2) ula_r2 <= ula_operand;
    end

    assign ula_result = ula_fn(sel_ula, ula_r1, ula_r2);
    assign cmp_bit    = ula_cmp(sel_ula, ula_r1, ula_r2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every data-stack write must match the head of the expected queue
    always @(negedge clk) begin
        if (stack_we === 1'b1) begin
            we_total++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(stack_we), 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr_data", 32'({stack_addr, stack_wdata}), 32'(e));
            end
        end
    end

    task automatic apply_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_count = 0;
        exp_q.delete();
    endtask

    task automatic wait_ready();
        int w = 0;
        while (op_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(op_ready), 32'd1);
    endtask

    // drive one opcode from a negedge; returns at a negedge with the DUT back in IDLE
    task automatic do_op(input logic [3:0] code, input logic [DW-1:0] data);
        int need, lat, exp_cnt_done;
        logic exp_uf, exp_full, exp_we, exp_ovf, exp_comp, exp_cmp, exp_exec;
        int exp_n1, exp_n2, exp_tos;
        logic [DW-1:0] a, b, res;
        int lat_obs, n1, n2, n_ovf, n_comp, n_we, n_busy, cnt_done, tos_obs;
        logic uf_obs, full_obs, cmp_obs;
        logic [DW-1:0] v1, v2;
        logic [3:0] sel_done;

        need = (code == 4'd15) ? 0 : (code == 4'd8) ? 1 : 2;
        exp_uf = 0; exp_full = 0; exp_we = 0; exp_ovf = 0; exp_comp = 0; exp_cmp = 0;
        exp_exec = 0; exp_n1 = 0; exp_n2 = 0; exp_tos = 0; a = '0; b = '0;
        if (m_count < need) begin
            exp_uf = 1; lat = 1; exp_cnt_done = m_count;
        end else if (code == 4'd15 && m_count == DEPTH) begin
            exp_full = 1; lat = 1; exp_cnt_done = m_count;
        end else if (code == 4'd15) begin
            exp_q.push_back({AW'(m_count), data});
            m_stack[m_count] = data;
            exp_cnt_done = m_count;
            m_count++;
            exp_we = 1; lat = 1;
        end else begin
            exp_exec = 1;
            a = m_stack[m_count-1]; exp_n1 = 1; m_count--;
            if (need == 2) begin
                b = m_stack[m_count-1]; exp_n2 = 1; m_count--;
            end
            exp_cnt_done = m_count;
            lat = (need == 2) ? 5 : 3;
            if (code <= 4'd8) begin
                res = ula_fn(code, a, b);
                exp_q.push_back({AW'(m_count), res});
                m_stack[m_count] = res;
                m_count++;
                exp_we = 1;
                exp_ovf = (code <= 4'd4);
            end else begin
                exp_comp = 1; exp_tos = exp_cnt_done; exp_cmp = ula_cmp(code, a, b);
            end
        end

        wait_ready();
        op_valid = 1'b1;
        op_code  = code;
        op_data  = data;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 4'($urandom_range(0, 15));
        op_data  = DW'($urandom_range(0, 255));

        lat_obs = 0; n1 = 0; n2 = 0; n_ovf = 0; n_comp = 0; n_we = 0; n_busy = 0;
        cnt_done = -1; tos_obs = -1; uf_obs = 0; full_obs = 0; cmp_obs = 0;
        v1 = '0; v2 = '0; sel_done = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (op_ready) n_busy++;
            if (ctrl_op1) begin n1++; v1 = ula_operand; end
            if (ctrl_op2) begin n2++; v2 = ula_operand; end
            if (ctrl_ovf) n_ovf++;
            if (ctrl_comp) begin n_comp++; tos_obs = int'(tos); cmp_obs = cmp_bit; end
            if (stack_we) n_we++;
            if (err_uf) uf_obs = 1;
            if (err_full) full_obs = 1;
            if (done) begin
                lat_obs  = k;
                cnt_done = int'(count);
                sel_done = sel_ula;
                break;
            end
        end

        check("latency", 32'(lat_obs), 32'(lat));
        check("err_underflow", 32'(uf_obs), 32'(exp_uf));
        check("err_full", 32'(full_obs), 32'(exp_full));
        check("ready_while_busy", 32'(n_busy), 32'd0);
        check("op1_pulses", 32'(n1), 32'(exp_n1));
        check("op2_pulses", 32'(n2), 32'(exp_n2));
        if (exp_n1 == 1) check("op1_value", 32'(v1), 32'(a));
        if (exp_n2 == 1) check("op2_value", 32'(v2), 32'(b));
        check("ovf_pulses", 32'(n_ovf), 32'(exp_ovf));
        check("comp_pulses", 32'(n_comp), 32'(exp_comp));
        if (exp_comp) begin
            check("comp_tos", 32'(tos_obs), 32'(exp_tos));
            check("comp_bit", 32'(cmp_obs), 32'(exp_cmp));
        end
        check("we_pulses", 32'(n_we), 32'(exp_we));
        check("count_at_done", 32'(cnt_done), 32'(exp_cnt_done));
        check("sel_at_done", 32'(sel_done), exp_exec ? 32'(code) : 32'hF);
        @(negedge clk);
        check("count_after", 32'(count), 32'(m_count));
        check("ready_after", 32'(op_ready), 32'd1);
    endtask

    initial begin
        int we_snap;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = '0;
        op_data  = '0;
        m_count  = 0;
        for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(op_ready), 32'd1);
        check("rst_sel", 32'(sel_ula), 32'hF);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tos", 32'(tos), 32'd0);
        check("rst_operand", 32'(ula_operand), 32'd0);
        check("rst_strobes", 32'({done, err_uf, err_full, stack_we, ctrl_op1, ctrl_op2, ctrl_ovf, ctrl_comp}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(op_ready), 32'd1);

        // 5 + 3
        do_op(4'hF, 8'd5);
        do_op(4'hF, 8'd3);
        do_op(4'h0, 8'd0);
        check("mem_add_5_3", 32'(mem[0]), 32'd8);

        // wrapping add with overflow strobe, then subtract
        apply_reset();
        do_op(4'hF, 8'd200);
        do_op(4'hF, 8'd100);
        do_op(4'h0, 8'd0);
        check("mem_add_wrap", 32'(mem[0]), 32'd44);
        do_op(4'hF, 8'd7);
        do_op(4'hF, 8'd2);
        do_op(4'h1, 8'd0);
        check("mem_sub", 32'(mem[1]), 32'd5);

        // compare, then NOT
        apply_reset();
        do_op(4'hF, 8'd4);
        do_op(4'hF, 8'd9);
        do_op(4'hC, 8'd0);
        do_op(4'hF, 8'h0F);
        do_op(4'h8, 8'd0);
        check("mem_not", 32'(mem[0]), 32'hF0);

        // underflow on empty, then overflow of a full stack
        apply_reset();
        do_op(4'h0, 8'd0);
        for (int i = 0; i < DEPTH + 1; i++) do_op(4'hF, DW'(10 + i));
        check("full_count", 32'(count), 32'(DEPTH));

        // reset dropped mid-operation in LD2
        apply_reset();
        do_op(4'hF, 8'd1);
        do_op(4'hF, 8'd2);
        wait_ready();
        op_valid = 1'b1;
        op_code  = 4'h0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_ld2", 32'(ctrl_op2), 32'd1);
        we_snap = we_total;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_count", 32'(count), 32'd0);
        check("abort_sel", 32'(sel_ula), 32'hF);
        check("abort_we", 32'(stack_we), 32'd0);
        rst_n = 1'b1;
        m_count = 0;
        @(negedge clk);
        check("abort_ready", 32'(op_ready), 32'd1);
        check("abort_no_write", 32'(we_total - we_snap), 32'd0);
        do_op(4'hF, 8'd6);
        check("mem_after_abort", 32'(mem[0]), 32'd6);

        // random mix of all opcode classes
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            c = (($urandom_range(0, 2)) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            do_op(c, DW'($urandom_range(0, 255)));
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
